sram_bank_sequencer: RTL and testbench

// - Timing sequencer directly upstream of a bank of DW 4Kx1 static RAM parts (CE_N/WE_N/DI/DO style).
// - Takes one-at-a-time read/write requests over a valid/ready handshake.
// - Drives address, data, CE_N and WE_N with fixed setup, strobe and hold phases, so the async RAM

---
 rtl/sram_bank_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_sram_bank_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_sequencer.sv
// sram_bank_sequencer
//
// Timing sequencer for a bank of 1-bit-wide asynchronous static RAM parts
// (CE_N/WE_N/DI/DO). Accepts one read or write at a time over a valid/ready
// handshake. Each access is driven through fixed setup, strobe and hold phases
// so the RAM only sees a stable address and data while its strobes are low.
// Read data is captured as CE_N rises and returned with a one-cycle response.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  sequencer idle; request taken on valid & ready
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle response pulse
//   rsp_we     out  request type echoed with the response
//   rsp_rdata  out  read data, valid with rsp_valid & !rsp_we
//   ram_a      out  address to all parts
//   ram_di     out  data in, bit i to part i
//   ram_do     in   data out from the parts (Z while CE_N high)
//   ram_ce_n   out  chip enable, active low
//   ram_we_n   out  write enable, active low
//
// state  | meaning
// IDLE   | waiting for a request, strobes high, req_ready high
// SETUP  | address/data driven, strobes still high
// STROBE | CE_N low; WE_N low as well on a write
// HOLD   | strobes released, address/data held; response in first cycle

module sram_bank_sequencer #(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic          rsp_we,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do,
    output logic          ram_ce_n,
    output logic          ram_we_n
);

    localparam int MAX_CYC =
        (SETUP_CYC > STROBE_CYC) ?
            ((SETUP_CYC  > HOLD_CYC) ? SETUP_CYC  : HOLD_CYC) :
            ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The counter is loaded with (phase length - 1) and the phase ends on the
    // cycle it reads zero.
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          we_q, we_d;
    logic          tc;
    logic          accept;

    logic          req_ready_d;
    logic          rsp_valid_d;
    logic          rsp_we_d;
    logic [DW-1:0] rsp_rdata_d;
    logic [AW-1:0] ram_a_d;
    logic [DW-1:0] ram_di_d;
    logic          ram_ce_n_d;
    logic          ram_we_n_d;

    assign tc     = (cnt == '0);
    assign accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            ram_a     <= '0;
            ram_di    <= '0;
            ram_ce_n  <= 1'b1;
            ram_we_n  <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            we_q      <= we_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_we    <= rsp_we_d;
            rsp_rdata <= rsp_rdata_d;
            ram_a     <= ram_a_d;
            ram_di    <= ram_di_d;
            ram_ce_n  <= ram_ce_n_d;
            ram_we_n  <= ram_we_n_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            SETUP: begin
                if (tc) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            STROBE: begin
                if (tc) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (tc) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Computes the registered output values for the next cycle. Strobes are
    // derived from the next state so CE_N and WE_N always move on one edge.
    always_comb begin
        we_d        = we_q;
        ram_a_d     = ram_a;
        ram_di_d    = ram_di;
        ram_ce_n_d  = 1'b1;
        ram_we_n_d  = 1'b1;
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = 1'b0;
        rsp_we_d    = rsp_we;
        rsp_rdata_d = rsp_rdata;

        if (accept) begin
            we_d     = req_we;
            ram_a_d  = req_addr;
            ram_di_d = req_wdata;
        end

        if (state_d == STROBE) begin
            ram_ce_n_d = 1'b0;
            ram_we_n_d = ~we_q;
        end

        // Last strobe cycle: data from the parts is still driven, capture it
        // on the same edge that releases CE_N.
        if ((state == STROBE) && tc) begin
            rsp_valid_d = 1'b1;
            rsp_we_d    = we_q;
            if (!we_q) begin
                rsp_rdata_d = ram_do;
            end
        end
    end

endmodule

// File: tb/tb_sram_bank_sequencer.sv
module tb_sram_bank_sequencer;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int S_A = 1, ST_A = 2, H_A = 1;
    localparam int S_B = 2, ST_B = 3, H_B = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    logic          req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_we, ram_ce_n, ram_we_n;
    logic [DW-1:0] rsp_rdata, ram_di;
    logic [AW-1:0] ram_a;
    wire  [DW-1:0] ram_do;

    logic          b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [AW-1:0] b_req_addr  = '0;
    logic [DW-1:0] b_req_wdata = '0;
    logic          b_req_ready, b_rsp_valid, b_rsp_we, b_ram_ce_n, b_ram_we_n;
    logic [DW-1:0] b_rsp_rdata, b_ram_di;
    logic [AW-1:0] b_ram_a;
    wire  [DW-1:0] b_ram_do;

    logic [DW-1:0] mem_a [0:4095];
    logic [DW-1:0] mem_b [0:4095];

    logic [DW-1:0] model_a [int];
    logic [DW-1:0] model_b [int];
    logic [DW-1:0] last_rd;

    logic          tr_ce [40];
    logic          tr_we [40];
    logic [AW-1:0] tr_a  [40];
    logic [DW-1:0] tr_di [40];
    int            tr_len;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_bank_sequencer #(
        .AW(AW), .DW(DW), .SETUP_CYC(S_A), .STROBE_CYC(ST_A), .HOLD_CYC(H_A)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
        .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n)
    );

    sram_bank_sequencer #(
        .AW(AW), .DW(DW), .SETUP_CYC(S_B), .STROBE_CYC(ST_B), .HOLD_CYC(H_B)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_we(b_rsp_we), .rsp_rdata(b_rsp_rdata),
        .ram_a(b_ram_a), .ram_di(b_ram_di), .ram_do(b_ram_do),
        .ram_ce_n(b_ram_ce_n), .ram_we_n(b_ram_we_n)
    );

    // Behavioural RAM banks: read while CE_N low, write while both strobes low.
    assign ram_do   = ram_ce_n   ? {DW{1'bz}} : mem_a[ram_a];
    assign b_ram_do = b_ram_ce_n ? {DW{1'bz}} : mem_b[b_ram_a];

    always @(posedge clk) if (!ram_ce_n && !ram_we_n) mem_a[ram_a] <= ram_di;
    always @(posedge clk) if (!b_ram_ce_n && !b_ram_we_n) mem_b[b_ram_a] <= b_ram_di;

    // Runs one access on instance A (sel_b=0) or B (sel_b=1). Trace sample n is
    // taken just after the n-th edge following the acceptance edge (n=0 is
    // just after acceptance). lat = index of the sample where rsp_valid is seen.
    task automatic access(input bit sel_b, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit disturb,
                          output int lat, output int busy, output logic rwe,
                          output logic [DW-1:0] rdata, output bit ok);
        int   n;
        logic rdy;
        ok = 1'b0; lat = -1; busy = 0; rwe = 1'bx; rdata = 'x; tr_len = 0; rdy = 1'b0;
        n = 0;
        while (!(sel_b ? b_req_ready : req_ready) && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 60) return;
        if (sel_b) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; b_req_valid = 1'b0;
        for (n = 0; n < 40; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            tr_ce[n] = sel_b ? b_ram_ce_n : ram_ce_n;
            tr_we[n] = sel_b ? b_ram_we_n : ram_we_n;
            tr_a[n]  = sel_b ? b_ram_a    : ram_a;
            tr_di[n] = sel_b ? b_ram_di   : ram_di;
            tr_len   = n + 1;
            if (disturb && n == 1) begin
                req_valid = 1'b1; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
            end
            if (disturb && n == 3) req_valid = 1'b0;
            if ((sel_b ? b_rsp_valid : rsp_valid) && lat < 0) begin
                lat   = n;
                rwe   = sel_b ? b_rsp_we : rsp_we;
                rdata = sel_b ? b_rsp_rdata : rsp_rdata;
            end
            rdy = sel_b ? b_req_ready : req_ready;
            if (!rdy) busy++;
            else break;
        end
        ok = (lat >= 0) && rdy;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({ram_ce_n, ram_we_n, req_ready, rsp_valid, rsp_we} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_ctrl_a: got %b expected 11100", {ram_ce_n, ram_we_n, req_ready, rsp_valid, rsp_we});
        end
        checks++;
        if ({ram_a, ram_di, rsp_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data_a: got a=%h di=%h rd=%h expected zeros", ram_a, ram_di, rsp_rdata);
        end
        checks++;
        if ({b_ram_ce_n, b_ram_we_n, b_req_ready, b_rsp_valid, b_rsp_we} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_ctrl_b: got %b expected 11100", {b_ram_ce_n, b_ram_we_n, b_req_ready, b_rsp_valid, b_rsp_we});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        last_rd = '0;
        checks++;
        if (req_ready !== 1'b1 || ram_ce_n !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle: got ready=%b ce_n=%b expected 1 1", req_ready, ram_ce_n);
        end
    endtask

    task automatic test_write_read;
        int lat, busy; logic rwe; logic [DW-1:0] rdata; bit ok;
        access(1'b0, 1'b1, 12'h5A5, 32'hDEADBEEF, 1'b0, lat, busy, rwe, rdata, ok);
        model_a[12'h5A5] = 32'hDEADBEEF;
        checks++;
        if (!ok || lat != S_A + ST_A || busy != S_A + ST_A + H_A || rwe !== 1'b1) begin
            failures++;
            $display("FAIL wr_rsp: got ok=%0d lat=%0d busy=%0d rsp_we=%b expected 1 %0d %0d 1",
                     ok, lat, busy, rwe, S_A + ST_A, S_A + ST_A + H_A);
        end
        access(1'b0, 1'b0, 12'h5A5, 32'h0, 1'b0, lat, busy, rwe, rdata, ok);
        checks++;
        if (!ok || rdata !== model_a[12'h5A5] || rwe !== 1'b0 || lat + 1 != S_A + ST_A + 1) begin
            failures++;
            $display("FAIL rd_rsp: got ok=%0d rdata=%h rsp_we=%b cycle=%0d expected %h 0 %0d",
                     ok, rdata, rwe, lat + 1, model_a[12'h5A5], S_A + ST_A + 1);
        end
        last_rd = model_a[12'h5A5];
        access(1'b0, 1'b1, 12'h123, 32'h0BAD_F00D, 1'b0, lat, busy, rwe, rdata, ok);
        model_a[12'h123] = 32'h0BAD_F00D;
        checks++;
        if (!ok || rdata !== last_rd) begin
            failures++;
            $display("FAIL wr_keeps_rdata: got ok=%0d rdata=%h expected %h", ok, rdata, last_rd);
        end
    endtask

    task automatic test_strobe_timing;
        int lat, busy, low, first, last; bit coinc, stable, we_hi; logic rwe; logic [DW-1:0] rdata; bit ok;
        logic [AW-1:0] addr; logic [DW-1:0] data;
        addr = AW'($urandom_range(16, 4000)); data = $urandom;
        access(1'b0, 1'b1, addr, data, 1'b0, lat, busy, rwe, rdata, ok);
        model_a[int'(addr)] = data;
        low = 0; first = -1; last = -1; coinc = 1; stable = 1;
        for (int i = 0; i < tr_len; i++) begin
            if (!tr_ce[i]) begin low++; if (first < 0) first = i; last = i; end
            if (tr_we[i] !== tr_ce[i]) coinc = 0;
            if (tr_a[i] !== addr || tr_di[i] !== data) stable = 0;
        end
        checks++;
        if (!ok || low != ST_A || !coinc) begin
            failures++;
            $display("FAIL wr_strobe_width: got ok=%0d low=%0d coincident=%0d expected 1 %0d 1", ok, low, coinc, ST_A);
        end
        checks++;
        if (first != S_A || tr_len - last - 2 != H_A) begin
            failures++;
            $display("FAIL wr_setup_hold: got setup=%0d hold=%0d expected %0d %0d", first, tr_len - last - 2, S_A, H_A);
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL wr_addr_data_stable: got unstable ram_a/ram_di expected %h/%h", addr, data);
        end
        access(1'b0, 1'b0, addr, 32'h0, 1'b0, lat, busy, rwe, rdata, ok);
        last_rd = rdata;
        low = 0; we_hi = 1;
        for (int i = 0; i < tr_len; i++) begin
            if (!tr_ce[i]) low++;
            if (tr_we[i] !== 1'b1) we_hi = 0;
        end
        checks++;
        if (!ok || !we_hi || low != ST_A || rdata !== data) begin
            failures++;
            $display("FAIL rd_strobe: got ok=%0d we_n_high=%0d low=%0d rdata=%h expected 1 1 %0d %h",
                     ok, we_hi, low, rdata, ST_A, data);
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] addrs [3]; logic [DW-1:0] datas [3]; int acc_cyc [3];
        int accepts, pulses, n, lat, busy; logic prev_rdy, rwe; logic [DW-1:0] rdata; bit ok;
        addrs[0] = '0; addrs[1] = 12'h001; addrs[2] = 12'hFFF;
        datas[0] = $urandom; datas[1] = datas[0] ^ 32'h0F0F_0001; datas[2] = ~datas[0];
        acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
        n = 0;
        while (!req_ready && n < 60) begin @(posedge clk); #1; n++; end
        accepts = 0; pulses = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = addrs[0]; req_wdata = datas[0];
        prev_rdy = req_ready;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (prev_rdy && req_valid) begin
                if (accepts < 3) acc_cyc[accepts] = c;
                model_a[int'(req_addr)] = req_wdata;
                accepts++;
                if (accepts < 3) begin
                    req_addr = addrs[accepts]; req_wdata = datas[accepts];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (c < 10 && req_ready) pulses++;
            prev_rdy = req_ready;
        end
        req_valid = 1'b0;
        checks++;
        if (accepts != 3 || pulses != 2) begin
            failures++;
            $display("FAIL b2b_accepts: got accepts=%0d ready_pulses=%0d expected 3 2", accepts, pulses);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] != S_A + ST_A + H_A + 1 || acc_cyc[2] - acc_cyc[1] != S_A + ST_A + H_A + 1) begin
            failures++;
            $display("FAIL b2b_period: got %0d %0d expected %0d", acc_cyc[1] - acc_cyc[0],
                     acc_cyc[2] - acc_cyc[1], S_A + ST_A + H_A + 1);
        end
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 1'b0, addrs[i], 32'h0, 1'b0, lat, busy, rwe, rdata, ok);
            last_rd = rdata;
            checks++;
            if (!ok || rdata !== datas[i]) begin
                failures++;
                $display("FAIL b2b_readback[%0d]: got ok=%0d rdata=%h expected %h", i, ok, rdata, datas[i]);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int lat, busy; bit stable; logic rwe; logic [DW-1:0] rdata; bit ok;
        logic [AW-1:0] addr; logic [DW-1:0] data;
        addr = 12'h2C4; data = $urandom;
        access(1'b0, 1'b1, addr, data, 1'b1, lat, busy, rwe, rdata, ok);
        model_a[int'(addr)] = data;
        stable = 1;
        for (int i = 0; i < tr_len; i++)
            if (tr_a[i] !== addr || tr_di[i] !== data) stable = 0;
        checks++;
        if (!ok || !stable || busy != S_A + ST_A + H_A) begin
            failures++;
            $display("FAIL ignore_busy_bus: got ok=%0d stable=%0d busy=%0d expected 1 1 %0d", ok, stable, busy, S_A + ST_A + H_A);
        end
        access(1'b0, 1'b0, addr, 32'h0, 1'b0, lat, busy, rwe, rdata, ok);
        last_rd = rdata;
        checks++;
        if (!ok || rdata !== data) begin
            failures++;
            $display("FAIL ignore_busy_data: got ok=%0d rdata=%h expected %h", ok, rdata, data);
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] written [$]; logic [AW-1:0] addr; logic [DW-1:0] data, exp;
        int lat, busy; logic we, rwe; logic [DW-1:0] rdata; bit ok;
        for (int i = 0; i < 12; i++) begin
            we = (written.size() == 0) || ($urandom_range(0, 1) == 1);
            if (we) begin
                case ($urandom_range(0, 3))
                    0:       addr = '0;
                    1:       addr = 12'hFFF;
                    default: addr = AW'($urandom);
                endcase
                data = $urandom;
                exp  = last_rd;
            end else begin
                addr = written[$urandom_range(0, written.size() - 1)];
                data = $urandom;
                exp  = model_a[int'(addr)];
            end
            access(1'b0, we, addr, data, 1'b0, lat, busy, rwe, rdata, ok);
            if (we) begin
                model_a[int'(addr)] = data;
                written.push_back(addr);
            end else begin
                last_rd = exp;
            end
            checks++;
            if (!ok || rwe !== we || rdata !== exp || lat != S_A + ST_A) begin
                failures++;
                $display("FAIL random[%0d]: we=%b addr=%h got ok=%0d rsp_we=%b rdata=%h lat=%0d expected %b %h %0d",
                         i, we, addr, ok, rwe, rdata, lat, we, exp, S_A + ST_A);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat, busy, n; bit seen; logic rwe; logic [DW-1:0] rdata; bit ok;
        logic [AW-1:0] addr; logic [DW-1:0] data;
        n = 0;
        while (!req_ready && n < 60) begin @(posedge clk); #1; n++; end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h010; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ram_ce_n !== 1'b0 || ram_we_n !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_strobe: got ce_n=%b we_n=%b expected 0 0", ram_ce_n, ram_we_n);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ram_ce_n !== 1'b1 || ram_we_n !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_release: got ce_n=%b we_n=%b rsp_valid=%b expected 1 1 0", ram_ce_n, ram_we_n, rsp_valid);
        end
        model_a.delete(12'h010);
        last_rd = '0;
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_ready_after: got %b expected 1", req_ready);
        end
        repeat (5) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mid_no_rsp: got rsp_valid=1 expected no response");
        end
        addr = 12'h7E1; data = $urandom;
        access(1'b0, 1'b1, addr, data, 1'b0, lat, busy, rwe, rdata, ok);
        model_a[int'(addr)] = data;
        access(1'b0, 1'b0, addr, 32'h0, 1'b0, lat, busy, rwe, rdata, ok);
        last_rd = rdata;
        checks++;
        if (!ok || rdata !== data || lat != S_A + ST_A) begin
            failures++;
            $display("FAIL mid_recover: got ok=%0d rdata=%h lat=%0d expected %h %0d", ok, rdata, lat, data, S_A + ST_A);
        end
    endtask

    task automatic test_param_sweep;
        int lat, busy, low; logic rwe; logic [DW-1:0] rdata; bit ok;
        logic [AW-1:0] addr; logic [DW-1:0] data;
        addr = AW'($urandom); data = $urandom;
        access(1'b1, 1'b1, addr, data, 1'b0, lat, busy, rwe, rdata, ok);
        model_b[int'(addr)] = data;
        low = 0;
        for (int i = 0; i < tr_len; i++) if (!tr_ce[i]) low++;
        checks++;
        if (!ok || busy != 7 || low != ST_B || rwe !== 1'b1) begin
            failures++;
            $display("FAIL sweep_wr: got ok=%0d busy=%0d strobe=%0d rsp_we=%b expected 1 7 %0d 1", ok, busy, low, rwe, ST_B);
        end
        access(1'b1, 1'b0, addr, 32'h0, 1'b0, lat, busy, rwe, rdata, ok);
        checks++;
        if (!ok || lat + 1 != 6 || busy != S_B + ST_B + H_B) begin
            failures++;
            $display("FAIL sweep_rd_timing: got ok=%0d rsp_cycle=%0d busy=%0d expected 1 6 7", ok, lat + 1, busy);
        end
        checks++;
        if (rdata !== model_b[int'(addr)] || rwe !== 1'b0) begin
            failures++;
            $display("FAIL sweep_rd_data: got rdata=%h rsp_we=%b expected %h 0", rdata, rwe, model_b[int'(addr)]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        last_rd = '0;
        test_reset();
        test_write_read();
        test_strobe_timing();
        test_back_to_back();
        test_ignore_busy();
        test_random();
        test_reset_mid();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
